// File: rtl/pll_reset_ctrl_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
// The state encoding, default parameter values and counter sizing live here.
package pll_reset_ctrl_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  localparam int DEF_RST_PULSE_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_MAX_RETRIES         = 7;
  localparam int DEF_SYNC_STAGES         = 2;

  // The counter only ever needs to reach (largest count - 1).
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Multi-stage flip-flop synchronizer for a single asynchronous level.
// Clears to zero on the asynchronous active-low reset.
module pll_lock_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses pll_rst, waits for a stable lock with timeout and
// retries, then releases the downstream reset. Runs on the PLL reference clock.
module pll_reset_ctrl
  import pll_reset_ctrl_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int SYNC_STAGES         = DEF_SYNC_STAGES
) (
  input  logic       clkin1,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       soft_restart,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       locked,
  output logic       lock_lost,
  output logic       timeout_err,
  output logic [3:0] retry_count
);

  localparam int CNT_W = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_next_count;
  logic             w_lock_s;
  logic             w_attempt_fail;
  logic [3:0]       w_retry_inc;
  logic [3:0]       w_next_retry;
  logic             w_next_lock_lost;
  logic             w_next_timeout;

  pll_lock_sync #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .i_clk  (clkin1),
    .i_rst_n(rst_n),
    .i_d    (pll_lock),
    .o_q    (w_lock_s)
  );

  // Outputs are decoded from the next state so they move on the same edge as the FSM.
  always_ff @(posedge clkin1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RESET_PLL;
      r_count     <= '0;
      pll_rst     <= 1'b1;
      sys_rst_n   <= 1'b0;
      locked      <= 1'b0;
      lock_lost   <= 1'b0;
      timeout_err <= 1'b0;
      retry_count <= '0;
    end else begin
      r_state     <= w_next_state;
      r_count     <= w_next_count;
      pll_rst     <= (w_next_state == RESET_PLL) || (w_next_state == FAIL);
      sys_rst_n   <= (w_next_state == RUN);
      locked      <= (w_next_state == RUN);
      lock_lost   <= w_next_lock_lost;
      timeout_err <= w_next_timeout;
      retry_count <= w_next_retry;
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_next_count     = r_count;
    w_attempt_fail   = 1'b0;
    w_retry_inc      = retry_count + 4'd1;
    w_next_retry     = retry_count;
    w_next_lock_lost = lock_lost;
    w_next_timeout   = timeout_err;

    case (r_state)
      RESET_PLL: begin
        if (r_count == RST_LAST) w_next_state = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (w_lock_s) w_next_state = STABLE;
        else if (r_count == TIMEOUT_LAST) w_attempt_fail = 1'b1;
      end
      STABLE: begin
        if (!w_lock_s) w_attempt_fail = 1'b1;
        else if (r_count == STABLE_LAST) w_next_state = RUN;
      end
      RUN: begin
        if (!w_lock_s) begin
          w_next_state     = RESET_PLL;
          w_next_lock_lost = 1'b1;
        end
      end
      FAIL: begin
        w_next_state = FAIL;
      end
      default: begin
        w_next_state = RESET_PLL;
      end
    endcase

    if (w_attempt_fail) begin
      w_next_retry = w_retry_inc;
      if (w_retry_inc == RETRY_LIMIT) begin
        w_next_state   = FAIL;
        w_next_timeout = 1'b1;
      end else begin
        w_next_state = RESET_PLL;
      end
    end

    // A restart request overrides everything, including staying parked in FAIL.
    if (soft_restart) begin
      w_next_state     = RESET_PLL;
      w_next_retry     = '0;
      w_next_lock_lost = 1'b0;
      w_next_timeout   = 1'b0;
    end

    if (soft_restart || (w_next_state != r_state)) begin
      w_next_count = '0;
    end else if ((r_state == RESET_PLL) || (r_state == WAIT_LOCK) || (r_state == STABLE)) begin
      w_next_count = r_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl with short timing parameters.
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.
module tb_pll_reset_ctrl;

  logic       clkin1 = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       soft_restart = 1'b0;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       locked;
  logic       lock_lost;
  logic       timeout_err;
  logic [3:0] retry_count;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clkin1 = ~clkin1;

  pll_reset_ctrl #(
    .RST_PULSE_CYCLES   (4),
    .LOCK_TIMEOUT_CYCLES(20),
    .LOCK_STABLE_CYCLES (8),
    .MAX_RETRIES        (3),
    .SYNC_STAGES        (2)
  ) dut (
    .clkin1      (clkin1),
    .rst_n       (rst_n),
    .pll_lock    (pll_lock),
    .soft_restart(soft_restart),
    .pll_rst     (pll_rst),
    .sys_rst_n   (sys_rst_n),
    .locked      (locked),
    .lock_lost   (lock_lost),
    .timeout_err (timeout_err),
    .retry_count (retry_count)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clkin1);
      #1;
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rst_n = 1'b0;
    pll_lock = 1'b0;
    soft_restart = 1'b0;
    step(3);
    n_checks++;
    if ({pll_rst, sys_rst_n, locked, lock_lost, timeout_err, retry_count} !== 9'b1_0000_0000) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %b required 100000000",
               {pll_rst, sys_rst_n, locked, lock_lost, timeout_err, retry_count});
    end
  endtask

  task automatic test_nominal();
    int width;
    $display("[TB] test_nominal");
    rst_n = 1'b1;
    width = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      width++;
      if (pll_rst === 1'b0) break;
    end
    n_checks++;
    if (width !== 4) begin
      n_fail++;
      $display("[TB] FAIL nominal_pll_rst_width: got %0d required 4", width);
    end
    step(2);
    pll_lock = 1'b1;
    step(10);
    n_checks++;
    if ({sys_rst_n, locked} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL nominal_early_release: got %b required 00", {sys_rst_n, locked});
    end
    step(1);
    n_checks++;
    if ({sys_rst_n, locked, pll_rst} !== 3'b110) begin
      n_fail++;
      $display("[TB] FAIL nominal_release: got %b required 110", {sys_rst_n, locked, pll_rst});
    end
    n_checks++;
    if (retry_count !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL nominal_retry: got %0d required 0", retry_count);
    end
  endtask

  task automatic test_lock_lost();
    int width;
    $display("[TB] test_lock_lost");
    pll_lock = 1'b0;
    step(2);
    n_checks++;
    if (sys_rst_n !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL loss_early_fall: got %b required 1", sys_rst_n);
    end
    step(1);
    n_checks++;
    if ({sys_rst_n, locked, lock_lost, pll_rst} !== 4'b0011) begin
      n_fail++;
      $display("[TB] FAIL loss_fall: got %b required 0011", {sys_rst_n, locked, lock_lost, pll_rst});
    end
    width = 1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (pll_rst === 1'b0) break;
      width++;
    end
    n_checks++;
    if (width !== 4) begin
      n_fail++;
      $display("[TB] FAIL loss_pll_rst_width: got %0d required 4", width);
    end
    step(3);
    pll_lock = 1'b1;
    n_checks++;
    if (retry_count !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL loss_retry: got %0d required 0", retry_count);
    end
    step(10);
    n_checks++;
    if (sys_rst_n !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL loss_early_rerun: got %b required 0", sys_rst_n);
    end
    step(1);
    n_checks++;
    if ({sys_rst_n, locked, lock_lost} !== 3'b111) begin
      n_fail++;
      $display("[TB] FAIL loss_rerun: got %b required 111", {sys_rst_n, locked, lock_lost});
    end
  endtask

  task automatic test_no_lock();
    logic       exp_rst;
    logic [3:0] exp_retry;
    logic       exp_to;
    $display("[TB] test_no_lock");
    pll_lock = 1'b0;
    step(3);
    n_checks++;
    if ({pll_rst, sys_rst_n} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL nolock_entry: got %b required 10", {pll_rst, sys_rst_n});
    end
    for (int i = 1; i <= 100; i++) begin
      step(1);
      exp_rst = (i < 4) || (i >= 24 && i < 28) || (i >= 48 && i < 52) || (i >= 72);
      exp_retry = (i >= 72) ? 4'd3 : (i >= 48) ? 4'd2 : (i >= 24) ? 4'd1 : 4'd0;
      exp_to = (i >= 72);
      n_checks++;
      if ({pll_rst, retry_count, timeout_err, lock_lost, sys_rst_n} !== {exp_rst, exp_retry, exp_to, 1'b1, 1'b0}) begin
        n_fail++;
        $display("[TB] FAIL nolock_cycle_%0d: got rst=%b retry=%0d to=%b lost=%b sys=%b required rst=%b retry=%0d to=%b lost=1 sys=0",
                 i, pll_rst, retry_count, timeout_err, lock_lost, sys_rst_n, exp_rst, exp_retry, exp_to);
      end
    end
  endtask

  task automatic test_fail_recovery();
    $display("[TB] test_fail_recovery");
    soft_restart = 1'b1;
    step(1);
    soft_restart = 1'b0;
    n_checks++;
    if ({timeout_err, retry_count, lock_lost, pll_rst} !== 7'b0_0000_01) begin
      n_fail++;
      $display("[TB] FAIL recover_clear: got to=%b retry=%0d lost=%b rst=%b required 0 0 0 1",
               timeout_err, retry_count, lock_lost, pll_rst);
    end
    step(3);
    n_checks++;
    if (pll_rst !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL recover_pulse_short: got %b required 1", pll_rst);
    end
    step(1);
    n_checks++;
    if (pll_rst !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL recover_pulse_long: got %b required 0", pll_rst);
    end
    pll_lock = 1'b1;
    step(10);
    n_checks++;
    if (sys_rst_n !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL recover_early_run: got %b required 0", sys_rst_n);
    end
    step(1);
    n_checks++;
    if ({sys_rst_n, locked} !== 2'b11) begin
      n_fail++;
      $display("[TB] FAIL recover_run: got %b required 11", {sys_rst_n, locked});
    end
  endtask

  task automatic test_stable_glitch();
    $display("[TB] test_stable_glitch");
    rst_n = 1'b0;
    pll_lock = 1'b1;
    step(2);
    rst_n = 1'b1;
    step(9);
    pll_lock = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      n_checks++;
      if (sys_rst_n !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL glitch_no_release_%0d: got %b required 0", i, sys_rst_n);
      end
    end
    pll_lock = 1'b1;
    n_checks++;
    if ({retry_count, pll_rst} !== 5'b0001_1) begin
      n_fail++;
      $display("[TB] FAIL glitch_retry: got retry=%0d rst=%b required retry=1 rst=1", retry_count, pll_rst);
    end
    step(3);
    n_checks++;
    if (pll_rst !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL glitch_pulse_short: got %b required 1", pll_rst);
    end
    step(1);
    n_checks++;
    if (pll_rst !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL glitch_pulse_long: got %b required 0", pll_rst);
    end
    step(8);
    n_checks++;
    if (sys_rst_n !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL glitch_early_run: got %b required 0", sys_rst_n);
    end
    step(1);
    n_checks++;
    if ({sys_rst_n, retry_count} !== 5'b1_0001) begin
      n_fail++;
      $display("[TB] FAIL glitch_run: got sys=%b retry=%0d required sys=1 retry=1", sys_rst_n, retry_count);
    end
  endtask

  task automatic test_async_reset();
    $display("[TB] test_async_reset");
    @(posedge clkin1);
    #2;
    n_checks++;
    if ({sys_rst_n, locked, retry_count} !== 6'b11_0001) begin
      n_fail++;
      $display("[TB] FAIL async_pre: got %b required 110001", {sys_rst_n, locked, retry_count});
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({pll_rst, sys_rst_n, locked, lock_lost, timeout_err, retry_count} !== 9'b1_0000_0000) begin
      n_fail++;
      $display("[TB] FAIL async_reset: got %b required 100000000",
               {pll_rst, sys_rst_n, locked, lock_lost, timeout_err, retry_count});
    end
    step(1);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_lock_lost();
    test_no_lock();
    test_fail_recovery();
    test_stable_glitch();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
